vending_ctrl_n: RTL and testbench
=================================

# vending_ctrl_n

Parametrised vending-machine controller, the next generation of the lab vending block. Supports N items with independent price and stock, a configuration load phase, saturating credit with coin rejection, runtime restock, and per-cycle deny and change reporting. It sits between the coin/selection front-end and the dispenser/change-return actuators. All outputs are registered.

## Interface
- N_ITEMS, 4, number of products (1..7); selection codes 1..N_ITEMS, 0 = no selection
- W, 8, money width (price, coin, credit, change)
- SW, 8, stock counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; clock clk
- cfg_valid  in  1  config word strobe (LOAD state only)
- cfg_data  in  W  config word: price0, stock0, price1, stock1, …; stock uses low SW bits
- coin  in  W  coin value inserted this cycle (0 = none)
- sel  in  3  item selection
- refund  in  1  refund request
- rs_valid  in  1  restock strobe
- rs_idx  in  3  restock item (1..N_ITEMS)
- rs_qty  in  SW  quantity added
- ready  out  1  configuration complete
- credit  out  W  current accumulated credit
- product  out  3  dispensed item code, valid with product_valid
- product_valid  out  1  one-cycle dispense pulse
- change  out  W  returned money, valid with change_valid
- change_valid  out  1  one-cycle change pulse
- deny  out  1  one-cycle pulse: selection rejected
- coin_rej  out  1  one-cycle pulse: coin rejected (overflow)
- empty  out  1  all stock zero after LOAD

## Operation
- States: LOAD, SERVE, EMPTY. Reset → LOAD, all prices/stock/credit 0, all outputs 0.
- LOAD: each cfg_valid consumes one word in order; after 2·N_ITEMS words → SERVE (or EMPTY if all stock 0), ready=1 from then on. In LOAD: sel, refund and restock ignored; nonzero coin returned immediately as change with change_valid.
- cfg_valid outside LOAD is ignored.
- SERVE, per cycle: eff = credit + coin. If eff > 2^W−1 → coin_rej=1, eff = credit (coin dropped).
- Priority: refund > sel. refund: change=eff, change_valid=1 if eff≠0, credit←0; sel is ignored that cycle.
- sel=k (1..N_ITEMS), eff ≥ price[k], stock[k] > 0: product=k, product_valid=1, change=eff−price[k], change_valid=1 (even if 0), stock[k]−1, credit←0.
- sel with insufficient eff, stock[k]=0, or k > N_ITEMS: deny=1, credit←eff.
- sel=0, no refund: credit←eff, no pulses.
- Restock (SERVE or EMPTY): stock[rs_idx] += rs_qty, saturating at 2^SW−1. rs_idx 0 or > N_ITEMS is ignored. Same-cycle vend of the same item: net = stock−1+qty, saturated.
- After any update, if sum of stock = 0 → EMPTY, empty=1.
- EMPTY: held credit auto-refunded on entry cycle+1; coins returned as change same-latency; nonzero sel → deny. Restock making any stock > 0 → SERVE, empty=0, next cycle.

## Timing
- Every output is registered: the response appears one cycle after the sampling edge. Pulses last exactly one cycle.
- Back-to-back transactions are accepted every cycle; no stall.
- Asynchronous reset mid-transaction clears all state, including credit. Credit is not refunded.
- credit reflects the post-update value of the previous edge.
- Wrap-around is impossible: credit saturates via coin rejection, stock saturates on restock, and stock never decrements below 0.

## Test plan
- Load N=4 (price/stock: 10/2, 20/1, 30/0, 5/3). Insert 15, sel=1 → product=1, change=5, stock1=1, credit=0.
- credit 250 plus coin 10 (W=8) → coin_rej=1, credit stays 250. Then refund → change=250, credit=0.
- sel=3 (stock 0) with credit 40 → deny=1, credit stays 40. sel=5 → deny. sel=2 with credit 15 → deny.
- Drain all stock, then: empty=1; coin 7 → change=7; sel=1 → deny. Restock idx2 qty3 → empty=0, vend item 2 succeeds.
- Same-cycle coin 5 + sel=4 at credit 0 → product=4, change=0. Same-cycle refund+sel → refund only.
- Assert rst low mid-LOAD and mid-SERVE → all outputs 0, ready=0, state LOAD, credit lost.

Source files
------------

// File: rtl/vending_ctrl_n.sv
// Vending controller: N items with price/stock loaded at start-up,
// saturating credit, restock, and registered dispense/change/deny pulses.
module vending_ctrl_n #(
  parameter int N_ITEMS = 4,
  parameter int W       = 8,
  parameter int SW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [W-1:0]  cfg_data,
  input  logic [W-1:0]  coin,
  input  logic [2:0]    sel,
  input  logic          refund,
  input  logic          rs_valid,
  input  logic [2:0]    rs_idx,
  input  logic [SW-1:0] rs_qty,
  output logic          ready,
  output logic [W-1:0]  credit,
  output logic [2:0]    product,
  output logic          product_valid,
  output logic [W-1:0]  change,
  output logic          change_valid,
  output logic          deny,
  output logic          coin_rej,
  output logic          empty
);

  typedef enum logic [1:0] {LOAD, SERVE, EMPTY} state_t;

  localparam int CW = $clog2(2 * N_ITEMS) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * N_ITEMS - 1);

  state_t r_state, w_state;

  logic [W-1:0]  r_price [N_ITEMS];
  logic [W-1:0]  w_price [N_ITEMS];
  logic [SW-1:0] r_stock [N_ITEMS];
  logic [SW-1:0] w_stock [N_ITEMS];
  logic [W-1:0]  r_credit, w_credit;
  logic [CW-1:0] r_cnt, w_cnt;

  logic [2:0]    r_prod, w_prod;
  logic [W-1:0]  r_chg, w_chg;
  logic          r_pv, w_pv;
  logic          r_cv, w_cv;
  logic          r_deny, w_deny;
  logic          r_rej, w_rej;
  logic          r_ready, r_empty;

  logic [W:0]         w_sum;
  logic               w_ovf;
  logic [W-1:0]       w_eff;
  logic               w_hit;
  logic [W-1:0]       w_pk;
  logic [SW-1:0]      w_sk;
  logic [N_ITEMS-1:0] w_selv, w_rsv, w_dec;
  logic [SW:0]        w_tmp;
  logic               w_done, w_any;

  // Coin that would overflow credit is dropped, not partially accepted.
  assign w_sum = {1'b0, r_credit} + {1'b0, coin};
  assign w_ovf = w_sum[W];
  assign w_eff = w_ovf ? r_credit : w_sum[W-1:0];

  always_comb begin
    w_hit  = 1'b0;
    w_pk   = '0;
    w_sk   = '0;
    w_selv = '0;
    w_rsv  = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      w_selv[i] = (sel == 3'(i + 1));
      w_rsv[i]  = rs_valid && (rs_idx == 3'(i + 1));
      if (w_selv[i]) begin
        w_hit = 1'b1;
        w_pk  = r_price[i];
        w_sk  = r_stock[i];
      end
    end
  end

  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_cnt    = r_cnt;
    w_price  = r_price;
    w_stock  = r_stock;
    w_prod   = '0;
    w_pv     = 1'b0;
    w_chg    = '0;
    w_cv     = 1'b0;
    w_deny   = 1'b0;
    w_rej    = 1'b0;
    w_dec    = '0;
    w_done   = 1'b0;
    w_tmp    = '0;
    w_any    = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_chg = coin;
        w_cv  = |coin;
        if (cfg_valid) begin
          w_cnt  = r_cnt + 1'b1;
          w_done = (r_cnt == LAST);
          for (int i = 0; i < N_ITEMS; i++) begin
            if (r_cnt == CW'(2 * i))
              w_price[i] = cfg_data;
            if (r_cnt == CW'(2 * i + 1))
              w_stock[i] = SW'(cfg_data);
          end
        end
      end
      SERVE: begin
        w_rej    = w_ovf;
        w_credit = w_eff;
        if (refund) begin
          w_chg    = w_eff;
          w_cv     = |w_eff;
          w_credit = '0;
        end else if (sel != 3'd0) begin
          if (w_hit && w_eff >= w_pk && w_sk != '0) begin
            w_prod   = sel;
            w_pv     = 1'b1;
            w_chg    = w_eff - w_pk;
            w_cv     = 1'b1;
            w_credit = '0;
            w_dec    = w_selv;
          end else begin
            w_deny = 1'b1;
          end
        end
      end
      EMPTY: begin
        w_rej    = w_ovf;
        w_chg    = w_eff;
        w_cv     = |w_eff;
        w_credit = '0;
        w_deny   = |sel;
      end
      default: w_state = LOAD;
    endcase
    // Vend and restock on one item combine before saturation.
    for (int i = 0; i < N_ITEMS; i++) begin
      if (r_state != LOAD) begin
        w_tmp = {1'b0, r_stock[i]}
              - {{SW{1'b0}}, w_dec[i]}
              + (w_rsv[i] ? {1'b0, rs_qty} : '0);
        w_stock[i] = w_tmp[SW] ? '1 : w_tmp[SW-1:0];
      end
      w_any = w_any | (|w_stock[i]);
    end
    if (r_state != LOAD || w_done)
      w_state = w_any ? SERVE : EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD;
    else      r_state <= w_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        r_price[i] <= '0;
        r_stock[i] <= '0;
      end
      r_prod  <= '0;
      r_pv    <= 1'b0;
      r_chg   <= '0;
      r_cv    <= 1'b0;
      r_deny  <= 1'b0;
      r_rej   <= 1'b0;
      r_ready <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_credit <= w_credit;
      r_cnt    <= w_cnt;
      r_price  <= w_price;
      r_stock  <= w_stock;
      r_prod   <= w_prod;
      r_pv     <= w_pv;
      r_chg    <= w_chg;
      r_cv     <= w_cv;
      r_deny   <= w_deny;
      r_rej    <= w_rej;
      r_ready  <= (w_state != LOAD);
      r_empty  <= (w_state == EMPTY);
    end
  end

  assign ready         = r_ready;
  assign credit        = r_credit;
  assign product       = r_prod;
  assign product_valid = r_pv;
  assign change        = r_chg;
  assign change_valid  = r_cv;
  assign deny          = r_deny;
  assign coin_rej      = r_rej;
  assign empty         = r_empty;

endmodule

// File: tb/tb_vending_ctrl_n.sv
// Directed vector bench for vending_ctrl_n (N_ITEMS=4, W=8, SW=8).
module tb_vending_ctrl_n;

  typedef struct packed {
    logic       cfgv;
    logic [7:0] cd;
    logic [7:0] coin;
    logic [2:0] sel;
    logic       rf;
    logic       rv;
    logic [2:0] ri;
    logic [7:0] rq;
  } in_t;

  typedef struct packed {
    logic [7:0] cr;
    logic [2:0] prod;
    logic       pv;
    logic [7:0] chg;
    logic       cv;
    logic       dn;
    logic       rj;
    logic       em;
    logic       rd;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = '0;
  logic [7:0] coin = '0;
  logic [2:0] sel = '0;
  logic       refund = 1'b0;
  logic       rs_valid = 1'b0;
  logic [2:0] rs_idx = '0;
  logic [7:0] rs_qty = '0;
  logic       ready, product_valid, change_valid;
  logic       deny, coin_rej, empty;
  logic [7:0] credit, change;
  logic [2:0] product;

  int checks = 0;
  int errors = 0;

  vending_ctrl_n #(.N_ITEMS(4), .W(8), .SW(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .coin(coin), .sel(sel), .refund(refund),
    .rs_valid(rs_valid), .rs_idx(rs_idx), .rs_qty(rs_qty),
    .ready(ready), .credit(credit),
    .product(product), .product_valid(product_valid),
    .change(change), .change_valid(change_valid),
    .deny(deny), .coin_rej(coin_rej), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic in_t I(
    input logic cv, input logic [7:0] cd, input logic [7:0] cn,
    input logic [2:0] s, input logic rf, input logic rv,
    input logic [2:0] ri, input logic [7:0] rq);
    return '{cv, cd, cn, s, rf, rv, ri, rq};
  endfunction

  function automatic out_t O(
    input logic [7:0] cr, input logic [2:0] p, input logic pv,
    input logic [7:0] ch, input logic cv, input logic dn,
    input logic rj, input logic em, input logic rd);
    return '{cr, p, pv, ch, cv, dn, rj, em, rd};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("cr=%0d p=%0d pv=%0b chg=%0d cv=%0b dn=%0b rj=%0b em=%0b rd=%0b",
      o.cr, o.prod, o.pv, o.chg, o.cv, o.dn, o.rj, o.em, o.rd);
  endfunction

  function automatic out_t act();
    return {credit, product, product_valid, change, change_valid,
            deny, coin_rej, empty, ready};
  endfunction

  task automatic compare(input out_t e, input string nm);
    out_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %s want %s", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic drive(input in_t i);
    cfg_valid = i.cfgv;
    cfg_data  = i.cd;
    coin      = i.coin;
    sel       = i.sel;
    refund    = i.rf;
    rs_valid  = i.rv;
    rs_idx    = i.ri;
    rs_qty    = i.rq;
  endtask

  task automatic step(input in_t i, input out_t e, input string nm);
    drive(i);
    @(posedge clk);
    @(negedge clk);
    compare(e, nm);
    drive('0);
  endtask

  task automatic async_reset(input string nm);
    #2 rst = 1'b0;
    #1 compare('0, nm);
    @(posedge clk);
    @(negedge clk);
    compare('0, {nm, "_hold"});
    rst = 1'b1;
  endtask

  vec_t tbl[$];
  logic [7:0] words [8];

  initial begin
    words = '{8'd10, 8'd2, 8'd20, 8'd1, 8'd30, 8'd0, 8'd5, 8'd3};

    tbl.push_back('{I(1,10,0,0,0,0,0,0),  O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,2,9,0,0,0,0,0),   O(0,0,0,9,1,0,0,0,0)});
    tbl.push_back('{I(1,20,0,1,1,1,1,5),  O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,1,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,30,0,0,0,0,0,0),  O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,0,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(0,0,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,5,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{I(1,3,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(1,99,15,0,0,0,0,0), O(15,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,0,1,0,0,0,0),   O(0,1,1,5,1,0,0,0,1)});
    tbl.push_back('{I(0,0,200,0,0,0,0,0), O(200,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,50,0,0,0,0,0),  O(250,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,10,0,0,0,0,0),  O(250,0,0,0,0,0,1,0,1)});
    tbl.push_back('{I(0,0,0,0,1,0,0,0),   O(0,0,0,250,1,0,0,0,1)});
    tbl.push_back('{I(0,0,200,0,0,0,0,0), O(200,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,55,0,0,0,0,0),  O(255,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,1,0,0,0,0,0),   O(255,0,0,0,0,0,1,0,1)});
    tbl.push_back('{I(0,0,0,0,1,0,0,0),   O(0,0,0,255,1,0,0,0,1)});
    tbl.push_back('{I(0,0,0,0,1,0,0,0),   O(0,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,40,0,0,0,0,0),  O(40,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,0,3,0,0,0,0),   O(40,0,0,0,0,1,0,0,1)});
    tbl.push_back('{I(0,0,0,5,0,0,0,0),   O(40,0,0,0,0,1,0,0,1)});
    tbl.push_back('{I(0,0,0,0,1,0,0,0),   O(0,0,0,40,1,0,0,0,1)});
    tbl.push_back('{I(0,0,15,0,0,0,0,0),  O(15,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,0,2,0,0,0,0),   O(15,0,0,0,0,1,0,0,1)});
    tbl.push_back('{I(0,0,5,2,0,0,0,0),   O(0,2,1,0,1,0,0,0,1)});
    tbl.push_back('{I(0,0,5,4,0,0,0,0),   O(0,4,1,0,1,0,0,0,1)});
    tbl.push_back('{I(0,0,10,4,1,0,0,0),  O(0,0,0,10,1,0,0,0,1)});
    tbl.push_back('{I(0,0,10,1,0,0,0,0),  O(0,1,1,0,1,0,0,0,1)});
    tbl.push_back('{I(0,0,5,4,0,0,0,0),   O(0,4,1,0,1,0,0,0,1)});
    tbl.push_back('{I(0,0,8,4,0,0,0,0),   O(0,4,1,3,1,0,0,1,1)});
    tbl.push_back('{I(0,0,7,0,0,0,0,0),   O(0,0,0,7,1,0,0,1,1)});
    tbl.push_back('{I(0,0,0,1,0,0,0,0),   O(0,0,0,0,0,1,0,1,1)});
    tbl.push_back('{I(0,0,0,0,0,1,0,5),   O(0,0,0,0,0,0,0,1,1)});
    tbl.push_back('{I(0,0,0,0,0,1,6,5),   O(0,0,0,0,0,0,0,1,1)});
    tbl.push_back('{I(0,0,0,0,0,1,2,3),   O(0,0,0,0,0,0,0,0,1)});
    tbl.push_back('{I(0,0,20,2,0,0,0,0),  O(0,2,1,0,1,0,0,0,1)});

    #3 compare('0, "reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k])
      step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    // Stock saturation, then same-cycle vend+restock, then drain.
    step(I(0,0,0,0,0,1,1,250), O(0,0,0,0,0,0,0,0,1), "rs250");
    step(I(0,0,0,0,0,1,1,10),  O(0,0,0,0,0,0,0,0,1), "rs_sat");
    step(I(0,0,10,1,0,1,1,1),  O(0,1,1,0,1,0,0,0,1), "vend_rs");
    step(I(0,0,20,2,0,0,0,0),  O(0,2,1,0,1,0,0,0,1), "drain2a");
    step(I(0,0,20,2,0,0,0,0),  O(0,2,1,0,1,0,0,0,1), "drain2b");
    for (int n = 1; n <= 255; n++)
      step(I(0,0,10,1,0,0,0,0),
           O(0,1,1,0,1,0,0,(n == 255),1),
           $sformatf("drain1_%0d", n));

    // Reset mid-SERVE with credit held.
    step(I(0,0,0,0,0,1,4,1),   O(0,0,0,0,0,0,0,0,1), "rs4");
    step(I(0,0,30,0,0,0,0,0),  O(30,0,0,0,0,0,0,0,1), "coin30");
    async_reset("rst_serve");
    step(I(0,0,6,1,0,0,0,0),   O(0,0,0,6,1,0,0,0,0), "post_rst");

    // Reset mid-LOAD, then a full reload must need all 8 words.
    step(I(1,10,0,0,0,0,0,0),  O(0,0,0,0,0,0,0,0,0), "pl0");
    step(I(1,2,0,0,0,0,0,0),   O(0,0,0,0,0,0,0,0,0), "pl1");
    step(I(1,20,0,0,0,0,0,0),  O(0,0,0,0,0,0,0,0,0), "pl2");
    async_reset("rst_load");
    for (int w = 0; w < 8; w++)
      step(I(1,words[w],0,0,0,0,0,0),
           O(0,0,0,0,0,0,0,0,(w == 7)),
           $sformatf("reload%0d", w));
    step(I(0,0,10,1,0,0,0,0),  O(0,1,1,0,1,0,0,0,1), "after_reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
